// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Pipeline barrier between two stages with a valid/ready handshake
//            and a 2-entry skid buffer. The skid entry lets in_ready come
//            straight from a register, which breaks the combinational path
//            from out_ready to in_ready. The control bus shows a bubble
//            encoding whenever no valid instruction is presented. Also has a
//            synchronous flush (branch squash) and a saturating counter of
//            stalled cycles.
// Ports    : clk, rst (sync, active-high), flush
//            in_valid / in_ready / in_data / in_ctrl    upstream side
//            out_valid / out_ready / out_data / out_ctrl downstream side
//            occupancy (0..2 held entries), stall_cnt (saturating)
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int                  DATA_W      = 64,
    parameter int                  CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]   BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter int                  CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // Main entry is the one presented downstream; the skid entry sits behind
    // it and is valid only while the main entry is valid.
    logic              r_mValid;
    logic [DATA_W-1:0] r_mData;
    logic [CTRL_W-1:0] r_mCtrl;
    logic              r_sValid;
    logic [DATA_W-1:0] r_sData;
    logic [CTRL_W-1:0] r_sCtrl;
    logic [CNT_W-1:0]  r_stallCnt;

    logic w_accept;
    logic w_mainFree;
    logic w_mainFromSkid;
    logic w_mainFromIn;
    logic w_skidFromIn;
    logic w_stall;

    assign in_ready   = ~r_sValid & ~rst;
    assign w_accept   = in_valid & in_ready;
    // Main entry can be overwritten when empty or consumed this cycle.
    assign w_mainFree = ~r_mValid | out_ready;

    assign w_mainFromSkid = w_mainFree & r_sValid;
    assign w_mainFromIn   = w_mainFree & ~r_sValid & w_accept;
    // Input lands in the skid entry when main is held, or when the skid
    // entry is moving forward into main in the same cycle.
    assign w_skidFromIn   = w_accept & ~w_mainFromIn;

    assign w_stall = r_mValid & ~out_ready;

    // Valid flags, control and the stall counter carry reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mValid   <= 1'b0;
            r_sValid   <= 1'b0;
            r_mCtrl    <= BUBBLE_CTRL;
            r_sCtrl    <= BUBBLE_CTRL;
            r_stallCnt <= '0;
        end else begin
            // Stall cycles count even while a flush is in progress.
            if (w_stall && (r_stallCnt != c_CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end

            if (flush) begin
                r_mValid <= 1'b0;
                r_sValid <= 1'b0;
            end else if (w_mainFree) begin
                if (r_sValid) begin
                    r_mValid <= 1'b1;
                    r_mCtrl  <= r_sCtrl;
                    if (w_accept) begin
                        r_sCtrl <= in_ctrl;
                    end else begin
                        r_sValid <= 1'b0;
                    end
                end else if (w_accept) begin
                    r_mValid <= 1'b1;
                    r_mCtrl  <= in_ctrl;
                end else begin
                    r_mValid <= 1'b0;
                end
            end else if (w_accept) begin
                r_sValid <= 1'b1;
                r_sCtrl  <= in_ctrl;
            end
        end
    end

    // Payload registers are not reset; their contents are only meaningful
    // while the matching valid flag is set.
    always_ff @(posedge clk) begin
        if (w_mainFromSkid) begin
            r_mData <= r_sData;
        end else if (w_mainFromIn) begin
            r_mData <= in_data;
        end
        if (w_skidFromIn) begin
            r_sData <= in_data;
        end
    end

    assign out_valid = r_mValid;
    assign out_data  = r_mData;
    assign out_ctrl  = r_mValid ? r_mCtrl : BUBBLE_CTRL;
    assign occupancy = {1'b0, r_mValid} + {1'b0, r_sValid};
    assign stall_cnt = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Self-checking bench for pipe_stage_skid. A queue-based reference
//            model tracks held entries and the stall count; a second
//            instance with a 4-bit counter exercises saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int          c_DW     = 64;
    localparam int          c_CW     = 8;
    localparam logic [7:0]  c_BUBBLE = 8'hE7;
    localparam int          c_CNTMAX = 65535;

    typedef struct packed {
        logic [c_DW-1:0] d;
        logic [c_CW-1:0] c;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, out_ready;
    logic              in_ready, out_valid;
    logic [c_DW-1:0]   in_data, out_data;
    logic [c_CW-1:0]   in_ctrl, out_ctrl;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt;

    logic              flush2, in_valid2, out_ready2, in_ready2, out_valid2;
    logic [7:0]        in_data2, out_data2;
    logic [3:0]        in_ctrl2, out_ctrl2;
    logic [1:0]        occupancy2;
    logic [3:0]        stall_cnt2;

    int checks = 0;
    int errors = 0;

    ent_t q[$];
    int   mCnt;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W(c_DW), .CTRL_W(c_CW), .BUBBLE_CTRL(c_BUBBLE), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(
        .DATA_W(8), .CTRL_W(4), .BUBBLE_CTRL(4'h0), .CNT_W(4)
    ) dutSat (
        .clk(clk), .rst(rst), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_ctrl(in_ctrl2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_ctrl(out_ctrl2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: apply inputs, compare outputs with the model, clock,
    // then advance the model by the same inputs.
    task automatic step(input logic iv, input logic [63:0] d, input logic [7:0] c,
                        input logic ordy, input logic fl, input logic r, input bit chk);
        int   sz;
        bit   take, acc;
        ent_t e;
        in_valid = iv; in_data = d; in_ctrl = c;
        out_ready = ordy; flush = fl; rst = r;
        #1;
        sz = q.size();
        if (chk) begin
            check("in_ready",  {63'd0, in_ready},  {63'd0, (!r && sz < 2)});
            check("out_valid", {63'd0, out_valid}, {63'd0, (sz > 0)});
            check("out_ctrl",  {56'd0, out_ctrl},  {56'd0, (sz > 0) ? q[0].c : c_BUBBLE});
            check("occupancy", {62'd0, occupancy}, 64'(sz));
            check("stall_cnt", {48'd0, stall_cnt}, 64'(mCnt));
            if (sz > 0) check("out_data", out_data, q[0].d);
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            mCnt = 0;
        end else begin
            take = (sz > 0) && ordy;
            acc  = iv && (sz < 2);
            if (sz > 0 && !ordy && mCnt < c_CNTMAX) mCnt++;
            if (fl) begin
                q.delete();
            end else begin
                if (take) void'(q.pop_front());
                if (acc) begin
                    e.d = d; e.c = c;
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0; mCnt = 0;
        flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
        in_data2 = 8'h5A; in_ctrl2 = 4'h9;
        @(negedge clk);

        // Reset held two cycles with in_valid high; state is unknown before
        // the first reset edge so checking starts on the second cycle.
        step(1'b1, 64'h1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Streaming with out_ready held high.
        step(1'b1, 64'hA11, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hA22, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hA33, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'h0,   8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'h0,   8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Backpressure: A and B fill the stage, C waits upstream.
        step(1'b1, 64'hB0A, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hB0B, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hB0C, 8'h4C, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hB0C, 8'h4C, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hB0C, 8'h4C, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hB0C, 8'h4C, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'h0,   8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'h0,   8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Flush a full stage while a new input is offered the same cycle.
        step(1'b1, 64'hF01, 8'h61, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hF02, 8'h62, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hF03, 8'h63, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 64'h0,   8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'h0,   8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Randomised traffic with sparse flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
                 1'b0, 1'b1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Saturation on the 4-bit counter instance: one entry, never consumed.
        // Its reset came from the shared rst at the start of the run.
        in_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        check("sat_occupancy", {62'd0, occupancy2}, 64'd1);
        check("sat_out_ctrl",  {60'd0, out_ctrl2},  64'h9);
        check("sat_start",     {60'd0, stall_cnt2}, 64'd0);
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("sat_cnt", {60'd0, stall_cnt2}, 64'((k < 15) ? k : 15));
        end
        check("sat_data", {56'd0, out_data2}, 64'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
